// File: rtl/output_drain_ctrl.sv
// Drains one output tile from the array output buffer into the quantizer through a one-entry
// registered forward stage, tracking per-element completion and flagging bad/stalled tiles.
module output_drain_ctrl #(
  parameter int unsigned MAX_N          = 16,
  parameter int unsigned N_BITS         = $clog2(MAX_N),
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TO_BITS        = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [N_BITS:0]   cfg_rows_i,
  input  logic [N_BITS:0]   cfg_cols_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_range_o,
  output logic              err_dup_o,
  output logic              err_timeout_o,
  output logic [2*N_BITS:0] elem_count_o,
  input  logic              buf_valid_i,
  input  logic [31:0]       buf_output_i,
  input  logic [N_BITS-1:0] buf_row_i,
  input  logic [N_BITS-1:0] buf_col_i,
  output logic              buf_consume_o,
  output logic              q_valid_o,
  output logic [31:0]       q_data_o,
  output logic [N_BITS-1:0] q_row_o,
  output logic [N_BITS-1:0] q_col_o,
  input  logic              q_ready_i
);

  localparam int unsigned CntW = 2 * N_BITS + 1;
  localparam int unsigned IdxW = 2 * N_BITS;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDrain = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [N_BITS:0]        rows_q, rows_d, cols_q, cols_d;
  logic [MAX_N*MAX_N-1:0] bitmap_q, bitmap_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [TO_BITS-1:0]     to_q, to_d;
  logic                   err_range_q, err_range_d;
  logic                   err_dup_q, err_dup_d;
  logic                   err_timeout_q, err_timeout_d;
  logic                   q_valid_q, q_valid_d;
  logic [31:0]            q_data_q, q_data_d;
  logic [N_BITS-1:0]      q_row_q, q_row_d, q_col_q, q_col_d;

  logic            xfer, in_range, cfg_bad;
  logic [IdxW-1:0] bit_idx;
  logic [CntW-1:0] total;

  // Must never look at buf_valid_i: the buffer's valid is a combinational function of consume.
  assign buf_consume_o = (state_q == StDrain) && (!q_valid_q || q_ready_i);
  assign xfer          = buf_consume_o && buf_valid_i;

  assign in_range = ((N_BITS+1)'(buf_row_i) < rows_q) && ((N_BITS+1)'(buf_col_i) < cols_q);
  assign bit_idx  = IdxW'(buf_row_i) * IdxW'(MAX_N) + IdxW'(buf_col_i);
  assign total    = CntW'(rows_q) * CntW'(cols_q);
  assign cfg_bad  = (cfg_rows_i == '0) || (cfg_cols_i == '0) ||
                    (cfg_rows_i > (N_BITS+1)'(MAX_N)) || (cfg_cols_i > (N_BITS+1)'(MAX_N));

  always_comb begin
    state_d       = state_q;
    rows_d        = rows_q;
    cols_d        = cols_q;
    bitmap_d      = bitmap_q;
    count_d       = count_q;
    to_d          = to_q;
    err_range_d   = err_range_q;
    err_dup_d     = err_dup_q;
    err_timeout_d = err_timeout_q;
    q_valid_d     = q_valid_q;
    q_data_d      = q_data_q;
    q_row_d       = q_row_q;
    q_col_d       = q_col_q;

    if (q_valid_q && q_ready_i) q_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          rows_d        = cfg_rows_i;
          cols_d        = cfg_cols_i;
          bitmap_d      = '0;
          count_d       = '0;
          to_d          = '0;
          err_dup_d     = 1'b0;
          err_timeout_d = 1'b0;
          err_range_d   = cfg_bad;
          state_d       = cfg_bad ? StDone : StDrain;
        end
      end
      StDrain: begin
        if (xfer) begin
          to_d = '0;
          if (!in_range) begin
            err_range_d = 1'b1;
          end else if (bitmap_q[bit_idx]) begin
            err_dup_d = 1'b1;
          end else begin
            bitmap_d[bit_idx] = 1'b1;
            count_d           = count_q + 1'b1;
            q_valid_d         = 1'b1;
            q_data_d          = buf_output_i;
            q_row_d           = buf_row_i;
            q_col_d           = buf_col_i;
            // Leave DRAIN on the completing edge so no further buffer entry is popped.
            if (count_d == total) state_d = StFlush;
          end
        end else if (to_q == TO_BITS'(TIMEOUT_CYCLES - 1)) begin
          err_timeout_d = 1'b1;
          q_valid_d     = 1'b0;
          state_d       = StDone;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      StFlush: begin
        if (!q_valid_q || q_ready_i) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      rows_q        <= '0;
      cols_q        <= '0;
      bitmap_q      <= '0;
      count_q       <= '0;
      to_q          <= '0;
      err_range_q   <= 1'b0;
      err_dup_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      q_valid_q     <= 1'b0;
      q_data_q      <= '0;
      q_row_q       <= '0;
      q_col_q       <= '0;
    end else begin
      state_q       <= state_d;
      rows_q        <= rows_d;
      cols_q        <= cols_d;
      bitmap_q      <= bitmap_d;
      count_q       <= count_d;
      to_q          <= to_d;
      err_range_q   <= err_range_d;
      err_dup_q     <= err_dup_d;
      err_timeout_q <= err_timeout_d;
      q_valid_q     <= q_valid_d;
      q_data_q      <= q_data_d;
      q_row_q       <= q_row_d;
      q_col_q       <= q_col_d;
    end
  end

  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StDone);
  assign err_range_o   = err_range_q;
  assign err_dup_o     = err_dup_q;
  assign err_timeout_o = err_timeout_q;
  assign elem_count_o  = count_q;
  assign q_valid_o     = q_valid_q;
  assign q_data_o      = q_data_q;
  assign q_row_o       = q_row_q;
  assign q_col_o       = q_col_q;

endmodule

// File: tb/tb_output_drain_ctrl.sv
// Directed bench for output_drain_ctrl: table of tile scenarios plus hand-written sequences for
// bad config, drain timeout and reset mid-tile. Buffer is modelled as a queue.
module tb_output_drain_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [4:0]  cfg_rows_i, cfg_cols_i;
  logic        busy_o, done_o, err_range_o, err_dup_o, err_timeout_o;
  logic [8:0]  elem_count_o;
  logic        buf_valid_i;
  logic [31:0] buf_output_i;
  logic [3:0]  buf_row_i, buf_col_i;
  logic        buf_consume_o;
  logic        q_valid_o;
  logic [31:0] q_data_o;
  logic [3:0]  q_row_o, q_col_o;
  logic        q_ready_i;

  output_drain_ctrl #(
    .MAX_N         (16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .cfg_rows_i   (cfg_rows_i),
    .cfg_cols_i   (cfg_cols_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_range_o  (err_range_o),
    .err_dup_o    (err_dup_o),
    .err_timeout_o(err_timeout_o),
    .elem_count_o (elem_count_o),
    .buf_valid_i  (buf_valid_i),
    .buf_output_i (buf_output_i),
    .buf_row_i    (buf_row_i),
    .buf_col_i    (buf_col_i),
    .buf_consume_o(buf_consume_o),
    .q_valid_o    (q_valid_o),
    .q_data_o     (q_data_o),
    .q_row_o      (q_row_o),
    .q_col_o      (q_col_o),
    .q_ready_i    (q_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0]  row;
    logic [3:0]  col;
    logic [31:0] data;
  } elem_t;

  typedef struct {
    int rows; int cols;
    int ins_at; int er; int ec;       // extra element pushed before in-order index ins_at
    int stall_at; int stall_len;      // q_ready low for this cycle window
    int exp_beats; int exp_xfers; int exp_count; int exp_range; int exp_dup;
  } vec_t;

  vec_t  tbl[7];
  elem_t fifo[$];
  elem_t got_q[$];
  elem_t exp_q[$];
  elem_t held;
  bit    feed_en, held_v, pop_pend, done_qv;
  int    n_tests, n_fail, cyc, beats, xfers, done_cnt, done_cyc, last_beat_cyc;
  int    stall_bad, stall_samples;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic drive_buf();
    if (feed_en && fifo.size() > 0) begin
      buf_valid_i  = 1'b1;
      buf_row_i    = fifo[0].row;
      buf_col_i    = fifo[0].col;
      buf_output_i = fifo[0].data;
    end else begin
      buf_valid_i = 1'b0;
    end
  endtask

  task automatic clear_stats();
    beats = 0; xfers = 0; done_cnt = 0; done_cyc = -1; last_beat_cyc = -100;
    stall_bad = 0; stall_samples = 0; held_v = 0; done_qv = 0;
    got_q.delete();
  endtask

  // One clock: sample handshakes at negedge, apply buffer pop just after posedge.
  task automatic step();
    elem_t cur;
    @(negedge clk_i);
    cur.row = q_row_o; cur.col = q_col_o; cur.data = q_data_o;
    if (q_valid_o && q_ready_i) begin
      got_q.push_back(cur);
      beats++;
      last_beat_cyc = cyc;
    end
    if (!q_ready_i && q_valid_o) begin
      stall_samples++;
      if (buf_consume_o) stall_bad++;
      if (held_v && (cur !== held)) stall_bad++;
      held_v = 1; held = cur;
    end else begin
      held_v = 0;
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
      done_qv  = q_valid_o;
    end
    pop_pend = buf_consume_o && buf_valid_i;
    @(posedge clk_i);
    #1;
    cyc++;
    if (pop_pend) begin
      xfers++;
      if (fifo.size() > 0) fifo.delete(0);
    end
    drive_buf();
  endtask

  task automatic load_tile(input int rows, input int cols, input int n, input int ins_at,
                           input int er, input int ec, input int t);
    elem_t e, x;
    fifo.delete();
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      e.row  = 4'(k / cols);
      e.col  = 4'(k % cols);
      e.data = {8'hA5, 8'(t), 8'(k), 8'(k ^ t)};
      if (k == ins_at) begin
        x.row  = 4'(er);
        x.col  = 4'(ec);
        x.data = 32'hDEAD_0000 | 32'(k);
        fifo.push_back(x);
      end
      fifo.push_back(e);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(input int rows, input int cols);
    feed_en    = 1'b1;
    q_ready_i  = 1'b1;
    cfg_rows_i = 5'(rows);
    cfg_cols_i = 5'(cols);
    start_i    = 1'b1;
    drive_buf();
    step();
    start_i = 1'b0;
  endtask

  task automatic run_tile(input vec_t v, input int t);
    int n, mism;
    clear_stats();
    n = v.rows * v.cols;
    load_tile(v.rows, v.cols, n, v.ins_at, v.er, v.ec, t);
    do_start(v.rows, v.cols);
    for (int k = 0; k < n * 2 + 40 && done_cnt == 0; k++) begin
      q_ready_i = !(k >= v.stall_at && k < v.stall_at + v.stall_len);
      step();
    end
    q_ready_i = 1'b1;
    step();
    step();
    mism = (got_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    check($sformatf("t%0d beats", t), beats, v.exp_beats);
    check($sformatf("t%0d transfers", t), xfers, v.exp_xfers);
    check($sformatf("t%0d elem_count", t), int'(elem_count_o), v.exp_count);
    check($sformatf("t%0d err_range", t), int'(err_range_o), v.exp_range);
    check($sformatf("t%0d err_dup", t), int'(err_dup_o), v.exp_dup);
    check($sformatf("t%0d err_timeout", t), int'(err_timeout_o), 0);
    check($sformatf("t%0d done pulses", t), done_cnt, 1);
    check($sformatf("t%0d done gap", t), done_cyc - last_beat_cyc, 1);
    check($sformatf("t%0d data mism", t), mism, 0);
    check($sformatf("t%0d stall hold bad", t), stall_bad, 0);
    check($sformatf("t%0d stall cycles", t), stall_samples, v.stall_len);
    check($sformatf("t%0d busy after", t), int'(busy_o), 0);
  endtask

  initial begin
    int   base;
    vec_t post;
    n_tests = 0; n_fail = 0; cyc = 0; feed_en = 0;
    //         rows cols ins er ec  st  sl beats xf  cnt rng dup
    tbl[0] = '{4,   4,   -1, 0, 0,  0,  0, 16,   16, 16, 0,  0};
    tbl[1] = '{2,   3,   -1, 0, 0,  3,  5, 6,    6,  6,  0,  0};
    tbl[2] = '{3,   3,   6,  1, 2,  0,  0, 9,    10, 9,  0,  1};
    tbl[3] = '{2,   2,   2,  3, 0,  0,  0, 4,    5,  4,  1,  0};
    tbl[4] = '{1,   1,   -1, 0, 0,  0,  0, 1,    1,  1,  0,  0};
    tbl[5] = '{16,  16,  -1, 0, 0,  0,  0, 256,  256, 256, 0, 0};
    tbl[6] = '{2,   2,   1,  0, 5,  0,  0, 4,    5,  4,  1,  0};
    post   = '{2,   2,   -1, 0, 0,  0,  0, 4,    4,  4,  0,  0};

    reset_i = 1'b1; start_i = 1'b0; cfg_rows_i = '0; cfg_cols_i = '0;
    buf_valid_i = 1'b0; buf_output_i = '0; buf_row_i = '0; buf_col_i = '0; q_ready_i = 1'b0;
    #3;
    check("rst busy", int'(busy_o), 0);
    check("rst done", int'(done_o), 0);
    check("rst err_range", int'(err_range_o), 0);
    check("rst err_dup", int'(err_dup_o), 0);
    check("rst err_timeout", int'(err_timeout_o), 0);
    check("rst elem_count", int'(elem_count_o), 0);
    check("rst buf_consume", int'(buf_consume_o), 0);
    check("rst q_valid", int'(q_valid_o), 0);
    #9 reset_i = 1'b0;
    @(posedge clk_i);
    #1;

    for (int t = 0; t < 7; t++) run_tile(tbl[t], t);

    // Illegal configs go straight to DONE with err_range.
    for (int b = 0; b < 2; b++) begin
      clear_stats();
      fifo.delete();
      do_start((b == 0) ? 0 : 4, (b == 0) ? 2 : 17);
      base = cyc;
      for (int k = 0; k < 6 && done_cnt == 0; k++) step();
      step();
      check($sformatf("badcfg%0d done cycle", b), done_cyc - base, 0);
      check($sformatf("badcfg%0d err_range", b), int'(err_range_o), 1);
      check($sformatf("badcfg%0d busy", b), int'(busy_o), 0);
      check($sformatf("badcfg%0d elem_count", b), int'(elem_count_o), 0);
    end

    // Drain timeout with an element still held in the q stage.
    clear_stats();
    load_tile(4, 4, 5, -1, 0, 0, 9);
    do_start(4, 4);
    base = cyc;
    for (int k = 0; k < 40 && done_cnt == 0; k++) begin
      q_ready_i = (k < 5);
      step();
    end
    check("tmo done cycle", done_cyc - base, 13);
    check("tmo q_valid at done", int'(done_qv), 0);
    check("tmo err_timeout", int'(err_timeout_o), 1);
    check("tmo elem_count", int'(elem_count_o), 5);
    check("tmo beats", beats, 4);
    q_ready_i = 1'b1;
    step();
    step();
    check("tmo q_valid after", int'(q_valid_o), 0);
    check("tmo busy after", int'(busy_o), 0);
    check("tmo done pulses", done_cnt, 1);

    // Asynchronous reset mid-tile, then a clean tile.
    clear_stats();
    load_tile(4, 4, 16, -1, 0, 0, 10);
    do_start(4, 4);
    for (int k = 0; k < 40 && elem_count_o != 9'd7; k++) step();
    check("mid elem_count", int'(elem_count_o), 7);
    check("mid q_valid", int'(q_valid_o), 1);
    #2 reset_i = 1'b1;
    #1;
    check("mid rst busy", int'(busy_o), 0);
    check("mid rst q_valid", int'(q_valid_o), 0);
    check("mid rst elem_count", int'(elem_count_o), 0);
    check("mid rst consume", int'(buf_consume_o), 0);
    fifo.delete();
    drive_buf();
    #2 reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    run_tile(post, 11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
